// File: rtl/ram_multi_read_sync_if.sv
// Bus bundle for ram_multi_read_sync: one masked write port plus packed per-port read
// request/response signals.
interface ram_multi_read_sync_if #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned READ_PORTS    = 2,
    parameter int unsigned MASK_WIDTH    = 1
);
    logic                                 write_enable;
    logic [ADDRESS_WIDTH-1:0]             write_address;
    logic [MASK_WIDTH-1:0]                write_mask;
    logic [WIDTH-1:0]                     write_data;
    logic [READ_PORTS-1:0]                read_enable;
    logic [READ_PORTS*ADDRESS_WIDTH-1:0]  read_address;
    logic [READ_PORTS*WIDTH-1:0]          read_data;
    logic [READ_PORTS-1:0]                read_valid;

    modport master (
        output write_enable, write_address, write_mask, write_data, read_enable, read_address,
        input  read_data, read_valid
    );

    modport slave (
        input  write_enable, write_address, write_mask, write_data, read_enable, read_address,
        output read_data, read_valid
    );
endinterface

// File: rtl/ram_multi_read_sync.sv
// Single-clock RAM: one lane-masked write port, READ_PORTS independent read ports with a
// 1- or 2-stage read pipeline; BYPASS selects write-first (1) or read-first (0) on collisions.
module ram_multi_read_sync #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned ADDRESS_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned READ_PORTS    = 2,
    parameter int unsigned MASK_WIDTH    = 1,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned BYPASS        = 1
) (
    input logic                  clock,
    input logic                  reset,
    ram_multi_read_sync_if.slave bus
);
    localparam int unsigned LANE = WIDTH / MASK_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_EXT = (ADDRESS_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] write_old;
    logic [WIDTH-1:0] write_word;
    logic             write_in_range;
    logic             write_fire;

    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < int'(MASK_WIDTH); i++) begin
            bit_mask[i*LANE +: LANE] = {LANE{bus.write_mask[i]}};
        end
    end

    assign write_in_range = {1'b0, bus.write_address} < DEPTH_EXT;
    assign write_fire     = bus.write_enable && write_in_range;
    assign write_old      = write_in_range ? mem_q[bus.write_address] : '0;
    // Merged word is both what gets stored and what a write-first collision returns.
    assign write_word     = (write_old & ~bit_mask) | (bus.write_data & bit_mask);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_fire) begin
            mem_q[bus.write_address] <= write_word;
        end
    end

    logic [WIDTH-1:0]      port_data [READ_PORTS];
    logic [READ_PORTS-1:0] port_valid;

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        logic [ADDRESS_WIDTH-1:0] addr;
        logic                     addr_in_range;
        logic                     collide;
        logic [WIDTH-1:0]         fetch_word;
        logic [WIDTH-1:0]         s1_data_q;
        logic                     s1_valid_q;

        assign addr          = bus.read_address[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign addr_in_range = {1'b0, addr} < DEPTH_EXT;
        assign collide       = write_fire && (addr == bus.write_address);

        always_comb begin
            fetch_word = addr_in_range ? mem_q[addr] : '0;
            if ((BYPASS != 0) && collide) begin
                fetch_word = write_word;
            end
        end

        // Data register only loads on a request so read_data holds between reads.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                s1_data_q  <= '0;
                s1_valid_q <= 1'b0;
            end else begin
                s1_valid_q <= bus.read_enable[p];
                if (bus.read_enable[p]) begin
                    s1_data_q <= fetch_word;
                end
            end
        end

        if (READ_LATENCY >= 2) begin : g_lat2
            logic [WIDTH-1:0] s2_data_q;
            logic             s2_valid_q;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    s2_data_q  <= '0;
                    s2_valid_q <= 1'b0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        s2_data_q <= s1_data_q;
                    end
                end
            end

            assign port_data[p]  = s2_data_q;
            assign port_valid[p] = s2_valid_q;
        end else begin : g_lat1
            assign port_data[p]  = s1_data_q;
            assign port_valid[p] = s1_valid_q;
        end
    end

    always_comb begin
        bus.read_data = '0;
        for (int p = 0; p < int'(READ_PORTS); p++) begin
            bus.read_data[p*WIDTH +: WIDTH] = port_data[p];
        end
    end

    assign bus.read_valid = port_valid;
endmodule

// File: tb/tb_ram_multi_read_sync.sv
// Directed bench for ram_multi_read_sync: four configurations sharing one clock and reset.
module tb_ram_multi_read_sync;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int unsigned n_compared   = 0;
    int unsigned n_mismatched = 0;

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // a: 8-bit write-first, b: 16-bit two lanes, c: read-first DEPTH=12, d: latency 2
    ram_multi_read_sync_if #(.WIDTH(8),  .ADDRESS_WIDTH(4), .READ_PORTS(2), .MASK_WIDTH(1)) bus_a ();
    ram_multi_read_sync_if #(.WIDTH(16), .ADDRESS_WIDTH(4), .READ_PORTS(2), .MASK_WIDTH(2)) bus_b ();
    ram_multi_read_sync_if #(.WIDTH(8),  .ADDRESS_WIDTH(4), .READ_PORTS(2), .MASK_WIDTH(1)) bus_c ();
    ram_multi_read_sync_if #(.WIDTH(8),  .ADDRESS_WIDTH(4), .READ_PORTS(2), .MASK_WIDTH(1)) bus_d ();

    ram_multi_read_sync #(.WIDTH(8), .DEPTH(16), .MASK_WIDTH(1), .READ_LATENCY(1), .BYPASS(1))
        u_dut_a (.clock(clock), .reset(reset), .bus(bus_a));
    ram_multi_read_sync #(.WIDTH(16), .DEPTH(16), .MASK_WIDTH(2), .READ_LATENCY(1), .BYPASS(1))
        u_dut_b (.clock(clock), .reset(reset), .bus(bus_b));
    ram_multi_read_sync #(.WIDTH(8), .DEPTH(12), .MASK_WIDTH(1), .READ_LATENCY(1), .BYPASS(0))
        u_dut_c (.clock(clock), .reset(reset), .bus(bus_c));
    ram_multi_read_sync #(.WIDTH(8), .DEPTH(16), .MASK_WIDTH(1), .READ_LATENCY(2), .BYPASS(1))
        u_dut_d (.clock(clock), .reset(reset), .bus(bus_d));

    initial begin
        bus_a.write_enable = 0; bus_a.write_address = 0; bus_a.write_mask = 0;
        bus_a.write_data = 0; bus_a.read_enable = 0; bus_a.read_address = 0;
        bus_b.write_enable = 0; bus_b.write_address = 0; bus_b.write_mask = 0;
        bus_b.write_data = 0; bus_b.read_enable = 0; bus_b.read_address = 0;
        bus_c.write_enable = 0; bus_c.write_address = 0; bus_c.write_mask = 0;
        bus_c.write_data = 0; bus_c.read_enable = 0; bus_c.read_address = 0;
        bus_d.write_enable = 0; bus_d.write_address = 0; bus_d.write_mask = 0;
        bus_d.write_data = 0; bus_d.read_enable = 0; bus_d.read_address = 0;

        // Requests during reset must be ignored: try writing 0xFF to a[0] and reading.
        bus_a.write_enable = 1; bus_a.write_address = 0; bus_a.write_mask = 1;
        bus_a.write_data = 8'hFF; bus_a.read_enable = 2'b11;
        tick();
        tick();
        check_eq("reset_valid_a", 32'(bus_a.read_valid), 32'h0);
        check_eq("reset_data_a", 32'(bus_a.read_data), 32'h0);
        check_eq("reset_valid_d", 32'(bus_d.read_valid), 32'h0);
        reset = 0;
        bus_a.write_enable = 0; bus_a.read_enable = 0;

        // Reset readback, back-to-back on a port 0.
        for (int i = 0; i < 16; i++) begin
            bus_a.read_enable = 2'b01;
            bus_a.read_address = {4'd0, 4'(i)};
            tick();
            check_eq($sformatf("readback_data_%0d", i), 32'(bus_a.read_data[7:0]), 32'h0);
            check_eq($sformatf("readback_valid_%0d", i), 32'(bus_a.read_valid), 32'h1);
        end
        bus_a.read_enable = 0;
        tick();
        check_eq("readback_valid_drop", 32'(bus_a.read_valid), 32'h0);

        // Masked writes on b.
        bus_b.write_enable = 1; bus_b.write_address = 3; bus_b.write_mask = 2'b11;
        bus_b.write_data = 16'hABCD;
        tick();
        bus_b.write_mask = 2'b01; bus_b.write_data = 16'h1234;
        tick();
        bus_b.write_mask = 2'b00; bus_b.write_data = 16'hFFFF;
        tick();
        bus_b.write_enable = 0;
        bus_b.read_enable = 2'b01; bus_b.read_address = {4'd0, 4'd3};
        tick();
        check_eq("mask_merge", 32'(bus_b.read_data[15:0]), 32'hAB34);
        // Partial-mask collision returns the merged word.
        bus_b.write_enable = 1; bus_b.write_mask = 2'b10; bus_b.write_data = 16'h5678;
        bus_b.read_enable = 2'b10; bus_b.read_address = {4'd3, 4'd0};
        tick();
        bus_b.write_enable = 0; bus_b.read_enable = 0;
        check_eq("mask_bypass", 32'(bus_b.read_data[31:16]), 32'h5634);

        // Collision: a is write-first, c is read-first; same stimulus on both.
        bus_a.write_enable = 1; bus_a.write_address = 5; bus_a.write_mask = 1;
        bus_a.write_data = 8'h11;
        bus_c.write_enable = 1; bus_c.write_address = 5; bus_c.write_mask = 1;
        bus_c.write_data = 8'h11;
        tick();
        bus_a.write_data = 8'h22; bus_a.read_enable = 2'b11; bus_a.read_address = {4'd5, 4'd5};
        bus_c.write_data = 8'h22; bus_c.read_enable = 2'b11; bus_c.read_address = {4'd5, 4'd5};
        tick();
        bus_a.write_enable = 0; bus_a.read_enable = 0;
        bus_c.write_enable = 0; bus_c.read_enable = 2'b01;
        check_eq("wf_port0", 32'(bus_a.read_data[7:0]), 32'h22);
        check_eq("wf_port1", 32'(bus_a.read_data[15:8]), 32'h22);
        check_eq("rf_port0", 32'(bus_c.read_data[7:0]), 32'h11);
        check_eq("rf_port1", 32'(bus_c.read_data[15:8]), 32'h11);
        tick();
        check_eq("rf_next", 32'(bus_c.read_data[7:0]), 32'h22);
        // Out-of-range read on DEPTH=12 returns 0 with valid.
        bus_c.read_address = {4'd0, 4'd13};
        tick();
        bus_c.read_enable = 0;
        check_eq("oor_data", 32'(bus_c.read_data[7:0]), 32'h0);
        check_eq("oor_valid", 32'(bus_c.read_valid), 32'h1);

        // Independent ports on a.
        bus_a.write_enable = 1; bus_a.write_address = 7; bus_a.write_data = 8'h77;
        tick();
        bus_a.write_address = 9; bus_a.write_data = 8'h99;
        tick();
        bus_a.write_enable = 0;
        bus_a.read_enable = 2'b11; bus_a.read_address = {4'd9, 4'd7};
        tick();
        bus_a.read_enable = 0;
        check_eq("indep_port0", 32'(bus_a.read_data[7:0]), 32'h77);
        check_eq("indep_port1", 32'(bus_a.read_data[15:8]), 32'h99);
        check_eq("indep_valid", 32'(bus_a.read_valid), 32'h3);
        tick();
        check_eq("hold_data", 32'(bus_a.read_data), 32'h9977);
        check_eq("hold_valid", 32'(bus_a.read_valid), 32'h0);

        // Latency-2 streaming on d port 1.
        for (int k = 0; k < 4; k++) begin
            bus_d.write_enable = 1; bus_d.write_address = 4'(k); bus_d.write_mask = 1;
            bus_d.write_data = 8'(8'h40 + k);
            tick();
        end
        bus_d.write_enable = 0;
        for (int c = 0; c < 7; c++) begin
            bus_d.read_enable = (c < 4) ? 2'b10 : 2'b00;
            bus_d.read_address = {4'(c), 4'd0};
            tick();
            check_eq($sformatf("l2_valid1_%0d", c), 32'(bus_d.read_valid[1]),
                     (c >= 1 && c <= 4) ? 32'h1 : 32'h0);
            check_eq($sformatf("l2_valid0_%0d", c), 32'(bus_d.read_valid[0]), 32'h0);
            if (c >= 1 && c <= 4) begin
                check_eq($sformatf("l2_data_%0d", c), 32'(bus_d.read_data[15:8]),
                         32'h40 + 32'(c - 1));
            end
        end
        // A write after stage-1 capture leaves the in-flight word alone.
        bus_d.read_enable = 2'b10; bus_d.read_address = {4'd0, 4'd0};
        tick();
        bus_d.read_enable = 0;
        bus_d.write_enable = 1; bus_d.write_address = 0; bus_d.write_data = 8'h99;
        tick();
        bus_d.write_enable = 0;
        check_eq("inflight_data", 32'(bus_d.read_data[15:8]), 32'h40);
        bus_d.read_enable = 2'b10;
        tick();
        bus_d.read_enable = 0;
        tick();
        check_eq("after_write", 32'(bus_d.read_data[15:8]), 32'h99);

        // Reset one cycle after a latency-2 request.
        bus_d.read_enable = 2'b01; bus_d.read_address = {4'd0, 4'd1};
        tick();
        bus_d.read_enable = 0;
        reset = 1;
        #1;
        check_eq("rst_async_data", 32'(bus_d.read_data), 32'h0);
        check_eq("rst_async_valid", 32'(bus_d.read_valid), 32'h0);
        for (int c = 0; c < 2; c++) begin
            tick();
            check_eq($sformatf("rst_hold_valid_%0d", c), 32'(bus_d.read_valid), 32'h0);
        end
        reset = 0;
        tick();
        check_eq("rst_release_valid", 32'(bus_d.read_valid), 32'h0);
        for (int c = 0; c < 17; c++) begin
            bus_d.read_enable = (c < 16) ? 2'b11 : 2'b00;
            bus_d.read_address = {4'(c), 4'(c)};
            tick();
            if (c >= 1) begin
                check_eq($sformatf("rst_clear_%0d", c - 1), 32'(bus_d.read_data), 32'h0);
                check_eq($sformatf("rst_clear_valid_%0d", c - 1), 32'(bus_d.read_valid), 32'h3);
            end
        end
        bus_d.read_enable = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
